// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: add/sub/and/or/slt, addi, lw, sw.
// One instruction is in flight at a time. A word is taken from the
// instruction port in IDLE and walks DECODE -> EXEC -> {MEM, WB} -> IDLE.
// The register file and data memory are local arrays, cleared by reset.
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready is high exactly while the FSM is in
// IDLE. instr_valid in any other state has no effect, and the word does not
// need to stay stable after the transfer edge.
//
// done and illegal are registered pulses. They are set on the edge that
// completes the last state of an instruction, so they are high during the
// first IDLE cycle that follows. The done latency after the accept edge is:
// 1 cycle for an illegal encoding, 3 cycles for R-type/addi/sw and 4 for lw.
module mips_multicycle_core #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] ALU_result,
    output logic              zero_flag,
    output logic              done,
    output logic              illegal,
    input  logic [4:0]        dbg_reg_addr,
    output logic [DATA_W-1:0] dbg_reg_data
);

    // Word-index width of the data memory. MEM_DEPTH must be at least 2.
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    // The register count, widened so that it can be compared with a 5-bit index.
    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Control and datapath registers.
    state_t            state_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr_q;
    logic              zero_q;
    logic              done_q;
    logic              illegal_q;

    // The array always has 32 entries so that any 5-bit field can index it.
    // Entries at or above NUM_REGS are never written and never read back.
    logic [DATA_W-1:0] regs [0:31];
    logic [DATA_W-1:0] mem  [0:MEM_DEPTH-1];

    // Fields of the instruction register.
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    // Instruction classification. The shamt field is ignored.
    logic is_rtype;
    logic funct_ok;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_legal;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);
    assign is_legal = (is_rtype && funct_ok) || is_addi || is_lw || is_sw;

    // The immediate is sign-extended to the datapath width.
    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = DATA_W'($signed(ir_q[15:0]));

    // Register 0 and indices at or above NUM_REGS are not backed by storage.
    // Reads of them return zero and writes to them are dropped.
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NUM_REGS_W);
    endfunction

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign rs_val       = idx_ok(rs)           ? regs[rs]           : '0;
    assign rt_val       = idx_ok(rt)           ? regs[rt]           : '0;
    assign dbg_reg_data = idx_ok(dbg_reg_addr) ? regs[dbg_reg_addr] : '0;

    // ALU result for the instruction in EXEC. addi, lw and sw all compute a base plus the offset.
    logic [DATA_W-1:0] alu_d;
    always_comb begin
        alu_d = a_q + imm_ext;
        if (is_rtype) begin
            case (funct)
                FN_ADD:  alu_d = a_q + b_q;
                FN_SUB:  alu_d = a_q - b_q;
                FN_AND:  alu_d = a_q & b_q;
                FN_OR:   alu_d = a_q | b_q;
                FN_SLT:  alu_d = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                default: alu_d = '0;
            endcase
        end
    end

    // Word address. Only the low bits of the byte address are used, so the address wraps around the memory.
    logic [MEM_AW-1:0] mem_idx;
    assign mem_idx = alu_q[MEM_AW+1:2];

    // Write-back port. R-type writes rd. addi and lw write rt.
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              mem_we;

    assign rf_waddr = is_rtype ? rd : rt;
    assign rf_wdata = is_lw ? mdr_q : alu_q;
    assign rf_we    = (state_q == S_WB) && idx_ok(rf_waddr);
    assign mem_we   = (state_q == S_MEM) && is_sw;

    // Sequencer: instruction latch, operand and result registers, status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir_q    <= instruction;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                    if (is_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    alu_q   <= alu_d;
                    zero_q  <= (alu_d == '0);
                    state_q <= (is_lw || is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (is_lw) begin
                        mdr_q   <= mem[mem_idx];
                        state_q <= S_WB;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_WB: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register file write in WB. Reset clears every entry, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Data memory write for sw in MEM. Reset clears every word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_idx] <= b_q;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign ALU_result  = alu_q;
    assign zero_flag   = zero_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core. The expected values come from an
// instruction-level model of architectural state: a register array, a memory
// array, and the last ALU value and zero flag.
module tb_mips_multicycle_core;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int MD = 128;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    logic          clk;
    logic          reset;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] ALU_result;
    logic          zero_flag;
    logic          done;
    logic          illegal;
    logic [4:0]    dbg_reg_addr;
    logic [DW-1:0] dbg_reg_data;

    int total = 0;
    int bad   = 0;

    // Architectural state of the reference model.
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [MD];
    logic [31:0] m_alu;
    logic        m_zero;

    mips_multicycle_core #(.DATA_W(DW), .NUM_REGS(NR), .MEM_DEPTH(MD)) dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .ALU_result   (ALU_result),
        .zero_flag    (zero_flag),
        .done         (done),
        .illegal      (illegal),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Instruction encoders.
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Reference model.
    function automatic logic [31:0] mreg(input int i);
        if (i == 0 || i >= NR) return 32'h0;
        return m_regs[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < MD; i++) m_mem[i] = 32'h0;
        m_alu  = 32'h0;
        m_zero = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] ins, output int lat, output logic ill);
        int rs, rt, rd, dest, word;
        logic [31:0] a, b, imm, res, wval;
        logic wr;
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        imm  = {{16{ins[15]}}, ins[15:0]};
        a    = mreg(rs);
        b    = mreg(rt);
        ill  = 1'b0;
        wr   = 1'b0;
        dest = 0;
        lat  = 3;
        res  = 32'h0;
        case (ins[31:26])
            OP_R: begin
                dest = rd;
                wr   = 1'b1;
                case (ins[5:0])
                    F_ADD:   res = a + b;
                    F_SUB:   res = a - b;
                    F_AND:   res = a & b;
                    F_OR:    res = a | b;
                    F_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ill = 1'b1;
                endcase
            end
            OP_ADDI: begin
                res  = a + imm;
                dest = rt;
                wr   = 1'b1;
            end
            OP_LW: begin
                res  = a + imm;
                dest = rt;
                wr   = 1'b1;
                lat  = 4;
            end
            OP_SW: begin
                res = a + imm;
            end
            default: ill = 1'b1;
        endcase
        word = int'((res >> 2) % MD);
        wval = (ins[31:26] == OP_LW) ? m_mem[word] : res;
        if (ill) begin
            lat = 1;
        end else begin
            m_alu  = res;
            m_zero = (res == 32'h0);
            if (ins[31:26] == OP_SW) m_mem[word] = b;
            if (wr && dest != 0 && dest < NR) m_regs[dest] = wval;
        end
    endtask

    // Driver. It issues one instruction and returns the number of cycles from
    // the accept edge to the done pulse, or -1 if no accept or no done occurs
    // within the cycle budget. It also returns the value of illegal sampled
    // with done.
    task automatic send(input logic [31:0] ins, output int lat, output logic ill);
        int w;
        lat = -1;
        ill = 1'b0;
        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) return;
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                ill = illegal;
                break;
            end
        end
    endtask

    task automatic test_reset();
        instr_valid  = 1'b0;
        instruction  = 32'h0;
        dbg_reg_addr = 5'd0;
        reset        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        total++; if (ALU_result !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", ALU_result); end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero_flag); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        dbg_reg_addr = 5'd1;
        #1;
        total++; if (dbg_reg_data !== 32'h0) begin bad++; $display("FAIL reset_reg1 got=%h exp=0", dbg_reg_data); end
    endtask

    task automatic test_arith();
        logic [31:0] prog [3];
        int lat, elat;
        logic ill, eill;
        prog[0] = enc_i(OP_ADDI, 0, 1, 5);
        prog[1] = enc_i(OP_ADDI, 0, 2, -3);
        prog[2] = enc_r(1, 2, 3, F_ADD);
        for (int i = 0; i < 3; i++) begin
            send(prog[i], lat, ill);
            model_step(prog[i], elat, eill);
            total++; if (lat !== 3) begin bad++; $display("FAIL arith%0d_latency got=%0d exp=3", i, lat); end
            total++; if (ill !== eill) begin bad++; $display("FAIL arith%0d_illegal got=%b exp=%b", i, ill, eill); end
            total++; if (ALU_result !== m_alu) begin bad++; $display("FAIL arith%0d_alu got=%h exp=%h", i, ALU_result, m_alu); end
        end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", zero_flag); end
        dbg_reg_addr = 5'd3;
        #1;
        total++; if (dbg_reg_data !== 32'd2) begin bad++; $display("FAIL add_reg3 got=%h exp=2", dbg_reg_data); end
    endtask

    task automatic test_sub_slt();
        int lat, elat;
        logic ill, eill;
        send(enc_r(1, 1, 4, F_SUB), lat, ill);
        model_step(enc_r(1, 1, 4, F_SUB), elat, eill);
        total++; if (lat !== 3) begin bad++; $display("FAIL sub_latency got=%0d exp=3", lat); end
        total++; if (ALU_result !== 32'h0) begin bad++; $display("FAIL sub_alu got=%h exp=0", ALU_result); end
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b exp=1", zero_flag); end
        send(enc_r(2, 1, 5, F_SLT), lat, ill);
        model_step(enc_r(2, 1, 5, F_SLT), elat, eill);
        total++; if (ALU_result !== 32'd1) begin bad++; $display("FAIL slt_alu got=%h exp=1", ALU_result); end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL slt_zero got=%b exp=0", zero_flag); end
        dbg_reg_addr = 5'd5;
        #1;
        total++; if (dbg_reg_data !== 32'd1) begin bad++; $display("FAIL slt_reg5 got=%h exp=1", dbg_reg_data); end
    endtask

    task automatic test_mem();
        int lat, elat;
        logic ill, eill;
        send(enc_i(OP_SW, 0, 3, 8), lat, ill);
        model_step(enc_i(OP_SW, 0, 3, 8), elat, eill);
        total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        send(enc_i(OP_LW, 0, 6, 8), lat, ill);
        model_step(enc_i(OP_LW, 0, 6, 8), elat, eill);
        total++; if (lat !== 4) begin bad++; $display("FAIL lw_latency got=%0d exp=4", lat); end
        total++; if (ALU_result !== 32'd8) begin bad++; $display("FAIL lw_alu got=%h exp=8", ALU_result); end
        dbg_reg_addr = 5'd6;
        #1;
        total++; if (dbg_reg_data !== 32'd2) begin bad++; $display("FAIL lw_reg6 got=%h exp=2", dbg_reg_data); end
        // A store to 4*MD+8 wraps onto word 2.
        send(enc_i(OP_SW, 0, 1, 4 * MD + 8), lat, ill);
        model_step(enc_i(OP_SW, 0, 1, 4 * MD + 8), elat, eill);
        send(enc_i(OP_LW, 0, 9, 8), lat, ill);
        model_step(enc_i(OP_LW, 0, 9, 8), elat, eill);
        dbg_reg_addr = 5'd9;
        #1;
        total++; if (dbg_reg_data !== 32'd5) begin bad++; $display("FAIL alias_reg9 got=%h exp=5", dbg_reg_data); end
    endtask

    task automatic test_r0_illegal();
        int lat, elat;
        logic ill, eill;
        send(enc_i(OP_ADDI, 0, 0, 7), lat, ill);
        model_step(enc_i(OP_ADDI, 0, 0, 7), elat, eill);
        total++; if (ALU_result !== 32'd7) begin bad++; $display("FAIL r0_alu got=%h exp=7", ALU_result); end
        dbg_reg_addr = 5'd0;
        #1;
        total++; if (dbg_reg_data !== 32'h0) begin bad++; $display("FAIL r0_read got=%h exp=0", dbg_reg_data); end
        send({6'h3F, 26'h2AB_CDEF}, lat, ill);
        model_step({6'h3F, 26'h2AB_CDEF}, elat, eill);
        total++; if (lat !== 1) begin bad++; $display("FAIL illop_latency got=%0d exp=1", lat); end
        total++; if (ill !== 1'b1) begin bad++; $display("FAIL illop_pulse got=%b exp=1", ill); end
        total++; if (ALU_result !== 32'd7) begin bad++; $display("FAIL illop_alu got=%h exp=7", ALU_result); end
        send(enc_r(1, 2, 11, 6'h21), lat, ill);
        model_step(enc_r(1, 2, 11, 6'h21), elat, eill);
        total++; if (lat !== elat || ill !== eill) begin bad++; $display("FAIL illfn got lat=%0d ill=%b exp lat=%0d ill=%b", lat, ill, elat, eill); end
        // Index 20 is at or above NUM_REGS: the write is dropped and reads return 0.
        send(enc_i(OP_ADDI, 0, 20, 9), lat, ill);
        model_step(enc_i(OP_ADDI, 0, 20, 9), elat, eill);
        send(enc_r(20, 1, 10, F_ADD), lat, ill);
        model_step(enc_r(20, 1, 10, F_ADD), elat, eill);
        dbg_reg_addr = 5'd10;
        #1;
        total++; if (dbg_reg_data !== 32'd5) begin bad++; $display("FAIL oob_reg10 got=%h exp=5", dbg_reg_data); end
        for (int i = 0; i < 32; i++) begin
            dbg_reg_addr = 5'(i);
            #1;
            total++; if (dbg_reg_data !== mreg(i)) begin bad++; $display("FAIL sweep1_reg%0d got=%h exp=%h", i, dbg_reg_data, mreg(i)); end
        end
    endtask

    task automatic test_back_to_back();
        localparam int HOLD = 40;
        int acc, dn, elat;
        logic eill;
        logic [31:0] ins;
        ins = enc_i(OP_ADDI, 8, 8, 1);
        acc = 0;
        dn  = 0;
        @(posedge clk);
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            if (instr_ready) acc++;
            if (done) dn++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        if (done) dn++;
        // Each addi occupies three busy cycles and one IDLE cycle.
        for (int i = 0; i < HOLD / 4; i++) model_step(ins, elat, eill);
        total++; if (acc !== HOLD / 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=%0d", acc, HOLD / 4); end
        total++; if (dn !== HOLD / 4) begin bad++; $display("FAIL b2b_dones got=%0d exp=%0d", dn, HOLD / 4); end
        dbg_reg_addr = 5'd8;
        #1;
        total++; if (dbg_reg_data !== mreg(8)) begin bad++; $display("FAIL b2b_reg8 got=%h exp=%h", dbg_reg_data, mreg(8)); end
    endtask

    task automatic test_reset_mid();
        int lat, elat;
        logic ill, eill;
        @(negedge clk);
        instruction = enc_r(1, 1, 7, F_ADD);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", instr_ready); end
        total++; if (ALU_result !== 32'h0) begin bad++; $display("FAIL rmid_alu got=%h exp=0", ALU_result); end
        total++; if (zero_flag !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rmid_flags got zero=%b done=%b ill=%b exp all 0", zero_flag, done, illegal); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_late_done got=%b exp=0", done); end
        dbg_reg_addr = 5'd7;
        #1;
        total++; if (dbg_reg_data !== 32'h0) begin bad++; $display("FAIL rmid_reg7 got=%h exp=0", dbg_reg_data); end
        dbg_reg_addr = 5'd1;
        #1;
        total++; if (dbg_reg_data !== 32'h0) begin bad++; $display("FAIL rmid_reg1 got=%h exp=0", dbg_reg_data); end
        send(enc_i(OP_LW, 0, 11, 8), lat, ill);
        model_step(enc_i(OP_LW, 0, 11, 8), elat, eill);
        total++; if (lat !== 4) begin bad++; $display("FAIL rmid_lw_latency got=%0d exp=4", lat); end
        dbg_reg_addr = 5'd11;
        #1;
        total++; if (dbg_reg_data !== 32'h0) begin bad++; $display("FAIL rmid_mem_cleared got=%h exp=0", dbg_reg_data); end
    endtask

    task automatic test_random();
        logic [5:0] ftab [5];
        logic [5:0] op, fn;
        logic [31:0] ins;
        int k, rs, rt, rd, lat, elat;
        logic ill, eill;
        ftab[0] = F_ADD; ftab[1] = F_SUB; ftab[2] = F_AND; ftab[3] = F_OR; ftab[4] = F_SLT;
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 9);
            rs = $urandom_range(0, 17);
            rt = $urandom_range(0, 17);
            rd = $urandom_range(0, 17);
            case (k)
                0, 1, 2, 3, 4: ins = enc_r(rs, rt, rd, ftab[k]) | (32'($urandom_range(0, 31)) << 6);
                5: ins = enc_i(OP_ADDI, rs, rt, $urandom_range(0, 65535));
                6: ins = enc_i(OP_LW, ($urandom_range(0, 1) != 0) ? 0 : rs, rt, $urandom_range(0, 127));
                7: ins = enc_i(OP_SW, ($urandom_range(0, 1) != 0) ? 0 : rs, rt, $urandom_range(0, 127));
                8: begin
                    do op = 6'($urandom_range(1, 63));
                    while (op == OP_ADDI || op == OP_LW || op == OP_SW);
                    ins = {op, 26'($urandom())};
                end
                default: begin
                    do fn = 6'($urandom_range(0, 63));
                    while (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT);
                    ins = enc_r(rs, rt, rd, fn);
                end
            endcase
            send(ins, lat, ill);
            model_step(ins, elat, eill);
            total++; if (lat !== elat) begin bad++; $display("FAIL rnd%0d_latency ins=%h got=%0d exp=%0d", n, ins, lat, elat); end
            total++; if (ill !== eill) begin bad++; $display("FAIL rnd%0d_illegal ins=%h got=%b exp=%b", n, ins, ill, eill); end
            total++; if (ALU_result !== m_alu) begin bad++; $display("FAIL rnd%0d_alu ins=%h got=%h exp=%h", n, ins, ALU_result, m_alu); end
            total++; if (zero_flag !== m_zero) begin bad++; $display("FAIL rnd%0d_zero ins=%h got=%b exp=%b", n, ins, zero_flag, m_zero); end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_reg_addr = 5'(i);
            #1;
            total++; if (dbg_reg_data !== mreg(i)) begin bad++; $display("FAIL rnd_sweep_reg%0d got=%h exp=%h", i, dbg_reg_data, mreg(i)); end
        end
    endtask

    initial begin
        reset        = 1'b1;
        instr_valid  = 1'b0;
        instruction  = 32'h0;
        dbg_reg_addr = 5'd0;
        test_reset();
        test_arith();
        test_sub_slt();
        test_mem();
        test_r0_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
